// File: rtl/ram_access_arbiter_if.sv
// rtl/ram_access_arbiter_if.sv - requester, RAM and status signals of the RAM access arbiter
//
// Purpose: bundles the CPU port (c_*), DMA port (d_*), RAM macro port (ram_*)
// and status (busy/owner) into one interface.
// Modports:
//   slave  - the arbiter: takes requests and ram_rdata, drives acks, read data,
//            RAM command and status.
//   master - the surroundings (control unit, DMA, RAM model): the opposite view.
interface ram_access_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  c_req;
  logic                  c_we;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic                  c_ack;
  logic [DATA_WIDTH-1:0] c_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_ack;
  logic [DATA_WIDTH-1:0] d_rdata;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_we;
  logic                  ram_re;
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic                  busy;
  logic                  owner;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  d_req, d_we, d_addr, d_wdata,
    input  ram_rdata,
    output c_ack, c_rdata, d_ack, d_rdata,
    output ram_addr, ram_wdata, ram_we, ram_re,
    output busy, owner
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output d_req, d_we, d_addr, d_wdata,
    output ram_rdata,
    input  c_ack, c_rdata, d_ack, d_rdata,
    input  ram_addr, ram_wdata, ram_we, ram_re,
    input  busy, owner
  );
endinterface

// File: rtl/ram_access_arbiter.sv
// rtl/ram_access_arbiter.sv - two-port (CPU/DMA) arbiter in front of a single-port synchronous RAM
//
// Purpose: grants the single-port data RAM to the CPU (fixed priority) or the
// DMA engine, issues one RAM command per grant and returns a one-cycle ack.
// A starvation counter forces a DMA grant after STARVE_LIMIT CPU grants taken
// while the DMA was waiting.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - ram_access_arbiter_if.slave: c_*/d_* request ports, ram_* RAM
//           command/read data, busy and owner status
module ram_access_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  ram_access_arbiter_if.slave bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ACCESS    = 2'd1,
    S_READ_WAIT = 2'd2
  } state_t;

  state_t                r_state;
  logic [3:0]            r_starve_cnt;
  logic                  r_owner;
  logic                  r_we;
  logic                  r_busy;
  logic                  r_c_ack;
  logic                  r_d_ack;
  logic                  r_ram_we;
  logic                  r_ram_re;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_wdata;
  logic [DATA_WIDTH-1:0] r_c_rdata;
  logic [DATA_WIDTH-1:0] r_d_rdata;

  logic                  w_grant_d;
  logic                  w_grant_c;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic                  w_rd_done;

  // DMA wins only when alone or when the CPU has starved it long enough.
  assign w_grant_d   = bus.d_req && (!bus.c_req || (r_starve_cnt == LIMIT));
  assign w_grant_c   = bus.c_req && !w_grant_d;
  assign w_sel_we    = w_grant_d ? bus.d_we    : bus.c_we;
  assign w_sel_addr  = w_grant_d ? bus.d_addr  : bus.c_addr;
  assign w_sel_wdata = w_grant_d ? bus.d_wdata : bus.c_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= 4'd0;
      r_owner      <= 1'b0;
      r_we         <= 1'b0;
      r_busy       <= 1'b0;
      r_c_ack      <= 1'b0;
      r_d_ack      <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_re     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_c_rdata    <= '0;
      r_d_rdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_c_ack <= 1'b0;
          r_d_ack <= 1'b0;
          if (w_grant_c || w_grant_d) begin
            r_owner     <= w_grant_d;
            r_we        <= w_sel_we;
            r_ram_addr  <= w_sel_addr;
            r_ram_wdata <= w_sel_wdata;
            r_ram_we    <= w_sel_we;
            r_ram_re    <= !w_sel_we;
            // A write completes in ACCESS, so its ack rides along with ram_we.
            r_c_ack     <= w_grant_c && w_sel_we;
            r_d_ack     <= w_grant_d && w_sel_we;
            r_busy      <= 1'b1;
            r_state     <= S_ACCESS;
          end
          if (w_grant_d) begin
            r_starve_cnt <= 4'd0;
          end else if (w_grant_c && bus.d_req) begin
            if (r_starve_cnt < LIMIT) begin
              r_starve_cnt <= r_starve_cnt + 4'd1;
            end
          end else if (!bus.d_req) begin
            r_starve_cnt <= 4'd0;
          end
        end
        S_ACCESS: begin
          r_ram_we <= 1'b0;
          r_ram_re <= 1'b0;
          if (r_we) begin
            r_c_ack <= 1'b0;
            r_d_ack <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_c_ack <= !r_owner;
            r_d_ack <= r_owner;
            r_state <= S_READ_WAIT;
          end
        end
        S_READ_WAIT: begin
          r_c_ack <= 1'b0;
          r_d_ack <= 1'b0;
          if (r_owner) begin
            r_d_rdata <= bus.ram_rdata;
          end else begin
            r_c_rdata <= bus.ram_rdata;
          end
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // RAM data arrives during READ_WAIT; pass it straight through alongside the
  // ack and keep the captured copy visible afterwards.
  assign w_rd_done = (r_state == S_READ_WAIT);

  // Acks are masked by reset so a transfer aborted in ACCESS/READ_WAIT never
  // shows a completion pulse.
  assign bus.c_ack     = r_c_ack && !reset;
  assign bus.d_ack     = r_d_ack && !reset;
  assign bus.c_rdata   = (w_rd_done && !r_owner) ? bus.ram_rdata : r_c_rdata;
  assign bus.d_rdata   = (w_rd_done &&  r_owner) ? bus.ram_rdata : r_d_rdata;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;
  assign bus.ram_we    = r_ram_we;
  assign bus.ram_re    = r_ram_re;
  assign bus.busy      = r_busy;
  assign bus.owner     = r_owner;

endmodule
